paddle_input: RTL and testbench
===============================

Name: paddle_input

Overview:
- Parametrised N-channel paddle front end between the ADC interface block and the VGA driver / processor.
- Captures one packed frame of raw ADC samples per conversion, on the falling edge of the ADC BUSY.
- Per channel: first-order IIR smoothing, then linear mapping into a screen Y range, then a deadband against jitter.
- Publishes per-paddle Y positions with a one-cycle valid strobe, plus freeze control and a sticky overrun flag.

Parameters:
- CHANNELS, 2, number of paddle channels (1..8).
- SAMPLE_W, 8, raw ADC sample width per channel.
- POS_W, 10, output position width per channel.
- Y_MIN, 0, smallest output position.
- Y_MAX, 420, mapping span end; requires Y_MIN <= Y_MAX < 2^POS_W.
- FILT_SHIFT, 2, IIR coefficient 1/2^FILT_SHIFT (0 = no filtering).
- DEADBAND, 2, minimum |new-old| (exclusive) that updates an output position.

Ports:
- clock_50MHz  in  1  system clock.
- RESET_n  in  1  reset, asynchronous, active-low.
- adc_busy  in  1  ADC conversion busy; a 1->0 transition marks fresh data.
- adc_data  in  CHANNELS*SAMPLE_W  packed samples, channel k at bits [k*SAMPLE_W +: SAMPLE_W].
- freeze  in  1  hold published positions (game pause / score screen).
- clr_overrun  in  1  synchronous clear of overrun.
- pos  out  CHANNELS*POS_W  packed paddle Y positions, same packing rule.
- pos_valid  out  1  one-cycle pulse: pos updated for a frame.
- overrun  out  1  sticky: a frame arrived while processing.

Behaviour:
- Reset (async, RESET_n=0): every pos field = Y_MIN; pos_valid=0; overrun=0; all filter accumulators = 0; primed flags = 0; busy_q = 0; state = IDLE.

Frame capture:
- busy_q is adc_busy registered.
- Frame edge = (busy_q==1 && adc_busy==0) sampled at a clock edge E0.
- In IDLE at E0: adc_data is latched into a sample register and the FSM goes to FILT(0).

FSM: IDLE -> FILT(k) -> MAP(k) -> ... -> FILT(CHANNELS-1) -> MAP(CHANNELS-1) -> DONE -> IDLE.
- One state per cycle, with no stalls.
- DONE at edge E0+2*CHANNELS+1; pos and pos_valid take effect at that edge.
- Latency from the busy falling edge to pos_valid high is 2*CHANNELS+1 cycles, i.e. 5 for the defaults.

Filter (FILT):
- acc is SAMPLE_W+FILT_SHIFT bits, unsigned; filt = acc >> FILT_SHIFT.
- Unprimed channel: acc = s << FILT_SHIFT; primed = 1.
- Primed channel: acc = acc + s - filt. This cannot overflow or underflow, since filt <= acc/2^FILT_SHIFT and s < 2^SAMPLE_W.

Map (MAP):
- cand = Y_MIN + ((filt * (Y_MAX-Y_MIN)) >> SAMPLE_W), floor, full-width product.
- Result is always within [Y_MIN, Y_MAX].

Deadband:
- The new position = cand if |cand - cur| > DEADBAND, or if the channel was primed in this frame, or if the frame is the first after freeze falls.
- Otherwise cur is kept.

Freeze:
- While freeze=1, filters keep running but pos is not written and pos_valid stays 0 at DONE.
- The first DONE after freeze returns to 0 bypasses the deadband on every channel.

Overrun:
- A frame edge seen in any state other than IDLE sets overrun=1 and the frame is dropped.
- The in-progress frame completes unaffected.
- clr_overrun=1 clears overrun; if a set and a clear happen in the same cycle, set wins.

Other rules:
- An edge coincident with DONE counts as overrun; the FSM is not back in IDLE until the next cycle.
- RESET_n low mid-frame aborts immediately to reset values; the next frame re-primes.
- adc_data is only sampled at capture; changes after capture are ignored.

Test Plan:
1. Defaults, after reset: pos=={0,0}, pos_valid=0, overrun=0. First frame ch0=255, ch1=0, busy falls at E0 -> at E0+5 pos_valid=1 for one cycle, ch0=418, ch1=0.
2. Filter step: prime ch0 with 0, then three frames of 128 -> ch0 filt 32, 56, 74 -> pos 52, 91, 121, with pos_valid pulsing each frame.
3. Deadband: prime ch0=100 -> pos 164. Next frame 104 (filt 101, cand 165, diff 1) -> pos stays 164 and pos_valid still pulses. Then frame 255 -> pos changes beyond 164.
4. Overrun: second busy falling edge at E0+2 -> overrun=1, exactly one pos_valid pulse at E0+5, second frame's data never appears. Pulse clr_overrun -> overrun=0. Set and clear in the same cycle -> overrun stays 1.
5. Freeze: freeze=1, frames with ch0=200 -> pos unchanged and no pos_valid. Drop freeze, then next frame -> pos_valid=1 and ch0 = mapped value, even when within DEADBAND.
6. Reset mid-frame: RESET_n=0 at E0+2 -> pos={0,0}, no pos_valid. Release, frame ch0=64 -> primed directly, pos ch0=105 at the new E0+5.

Source files
------------

// File: rtl/paddle_input_if.sv
// Paddle front-end bus: ADC-side frame inputs, control inputs and
// published paddle positions.
interface paddle_input_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned POS_W    = 10
);
    logic                         adc_busy;
    logic [CHANNELS*SAMPLE_W-1:0] adc_data;
    logic                         freeze;
    logic                         clr_overrun;
    logic [CHANNELS*POS_W-1:0]    pos;
    logic                         pos_valid;
    logic                         overrun;

    modport master (
        output adc_busy, adc_data, freeze, clr_overrun,
        input  pos, pos_valid, overrun
    );

    modport slave (
        input  adc_busy, adc_data, freeze, clr_overrun,
        output pos, pos_valid, overrun
    );
endinterface

// File: rtl/paddle_input.sv
// N-channel paddle front end. A frame of ADC samples is captured on the
// falling edge of adc_busy, then each channel is IIR-smoothed, mapped to
// a screen Y range and deadbanded before being published.
//
// state  | meaning
// IDLE   | waiting for a busy falling edge
// FILT   | update the IIR accumulator of channel r_ch
// MAP    | map the filtered value of channel r_ch to a Y candidate
// DONE   | apply deadband / freeze, publish positions
module paddle_input #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned POS_W      = 10,
    parameter int unsigned Y_MIN      = 0,
    parameter int unsigned Y_MAX      = 420,
    parameter int unsigned FILT_SHIFT = 2,
    parameter int unsigned DEADBAND   = 2
) (
    input  logic          clock_50MHz,
    input  logic          RESET_n,
    paddle_input_if.slave bus
);
    localparam int unsigned ACC_W  = SAMPLE_W + FILT_SHIFT;
    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned SPAN   = Y_MAX - Y_MIN;
    localparam int unsigned PROD_W = SAMPLE_W + POS_W;

    typedef enum logic [1:0] {S_IDLE, S_FILT, S_MAP, S_DONE} state_t;

    state_t                       r_state, w_state_nxt;
    logic [CH_W-1:0]              r_ch, w_ch_nxt;
    logic                         r_busy_q;
    logic [CHANNELS*SAMPLE_W-1:0] r_samples;
    logic [ACC_W-1:0]             r_acc  [CHANNELS];
    logic [CHANNELS-1:0]          r_primed;
    logic [CHANNELS-1:0]          r_fresh;
    logic [POS_W-1:0]             r_cand [CHANNELS];
    logic [POS_W-1:0]             r_pos  [CHANNELS];
    logic                         r_pos_valid;
    logic                         r_overrun;
    logic                         r_thaw;

    logic                         w_edge;
    logic [SAMPLE_W-1:0]          w_s;
    logic [ACC_W-1:0]             w_acc_cur;
    logic [SAMPLE_W-1:0]          w_filt;
    logic [ACC_W-1:0]             w_acc_new;
    logic [PROD_W-1:0]            w_prod;
    logic [POS_W-1:0]             w_cand;
    logic [POS_W-1:0]             w_pos_nxt [CHANNELS];
    logic [CHANNELS*POS_W-1:0]    w_pos_packed;

    assign w_edge    = r_busy_q & ~bus.adc_busy;
    assign w_s       = r_samples[r_ch*SAMPLE_W +: SAMPLE_W];
    assign w_acc_cur = r_acc[r_ch];
    assign w_filt    = SAMPLE_W'(w_acc_cur >> FILT_SHIFT);
    // Modular arithmetic is safe: the true result always fits in ACC_W.
    assign w_acc_new = r_primed[r_ch] ? (w_acc_cur + ACC_W'(w_s) - ACC_W'(w_filt))
                                      : (ACC_W'(w_s) << FILT_SHIFT);
    assign w_prod    = PROD_W'(w_filt) * PROD_W'(SPAN);
    assign w_cand    = POS_W'(Y_MIN) + POS_W'(w_prod >> SAMPLE_W);

    // Next-state: one state per cycle, walking FILT/MAP over every channel.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        case (r_state)
            S_IDLE: if (w_edge) begin
                w_state_nxt = S_FILT;
                w_ch_nxt    = '0;
            end
            S_FILT: w_state_nxt = S_MAP;
            S_MAP: begin
                if (r_ch == CH_W'(CHANNELS - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_FILT;
                    w_ch_nxt    = r_ch + CH_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Deadband decision per channel; fresh priming or a thaw bypasses it.
    always_comb begin
        logic [POS_W-1:0] diff;
        for (int k = 0; k < CHANNELS; k++) begin
            diff = (r_cand[k] > r_pos[k]) ? (r_cand[k] - r_pos[k]) : (r_pos[k] - r_cand[k]);
            w_pos_nxt[k] = r_pos[k];
            if ((32'(diff) > DEADBAND) || r_fresh[k] || r_thaw)
                w_pos_nxt[k] = r_cand[k];
        end
    end

    // Pack the per-channel positions onto the output bus.
    always_comb begin
        w_pos_packed = '0;
        for (int k = 0; k < CHANNELS; k++)
            w_pos_packed[k*POS_W +: POS_W] = r_pos[k];
    end

    assign bus.pos       = w_pos_packed;
    assign bus.pos_valid = r_pos_valid;
    assign bus.overrun   = r_overrun;

    // State and channel index registers.
    always_ff @(posedge clock_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
        end
    end

    // Busy edge detector and frame capture (only accepted in IDLE).
    always_ff @(posedge clock_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            r_busy_q  <= 1'b0;
            r_samples <= '0;
        end else begin
            r_busy_q <= bus.adc_busy;
            if (r_state == S_IDLE && w_edge)
                r_samples <= bus.adc_data;
        end
    end

    // IIR accumulator update; an unprimed channel is loaded directly.
    always_ff @(posedge clock_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int k = 0; k < CHANNELS; k++) r_acc[k] <= '0;
            r_primed <= '0;
            r_fresh  <= '0;
        end else if (r_state == S_FILT) begin
            r_acc[r_ch]    <= w_acc_new;
            r_primed[r_ch] <= 1'b1;
            r_fresh[r_ch]  <= ~r_primed[r_ch];
        end
    end

    // Mapped candidate per channel, consumed at DONE.
    always_ff @(posedge clock_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int k = 0; k < CHANNELS; k++) r_cand[k] <= POS_W'(Y_MIN);
        end else if (r_state == S_MAP) begin
            r_cand[r_ch] <= w_cand;
        end
    end

    // Publish positions at DONE unless frozen; remember a freeze for the thaw bypass.
    always_ff @(posedge clock_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int k = 0; k < CHANNELS; k++) r_pos[k] <= POS_W'(Y_MIN);
            r_pos_valid <= 1'b0;
            r_thaw      <= 1'b0;
        end else begin
            r_pos_valid <= 1'b0;
            if (bus.freeze) begin
                r_thaw <= 1'b1;
            end else if (r_state == S_DONE) begin
                for (int k = 0; k < CHANNELS; k++) r_pos[k] <= w_pos_nxt[k];
                r_pos_valid <= 1'b1;
                r_thaw      <= 1'b0;
            end
        end
    end

    // Sticky overrun: an edge outside IDLE drops the frame; set beats clear.
    always_ff @(posedge clock_50MHz or negedge RESET_n) begin
        if (!RESET_n)
            r_overrun <= 1'b0;
        else if (w_edge && r_state != S_IDLE)
            r_overrun <= 1'b1;
        else if (bus.clr_overrun)
            r_overrun <= 1'b0;
    end
endmodule

// File: tb/tb_paddle_input.sv
// Directed bench for paddle_input with hand-computed expected positions.
module tb_paddle_input;
    localparam int CH = 2;
    localparam int SW = 8;
    localparam int PW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #10 clk = ~clk;

    paddle_input_if #(.CHANNELS(CH), .SAMPLE_W(SW), .POS_W(PW)) u_if ();

    paddle_input #(.CHANNELS(CH), .SAMPLE_W(SW), .POS_W(PW)) dut (
        .clock_50MHz (clk),
        .RESET_n     (rst_n),
        .bus         (u_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        u_if.adc_busy    = 1'b0;
        u_if.adc_data    = '0;
        u_if.freeze      = 1'b0;
        u_if.clr_overrun = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns just after the capture edge E0.
    task automatic start_frame(input int d0, input int d1);
        @(negedge clk);
        u_if.adc_data = {SW'(d1), SW'(d0)};
        u_if.adc_busy = 1'b1;
        @(negedge clk);
        u_if.adc_busy = 1'b0;
        @(posedge clk);
    endtask

    task automatic finish_frame(input string tag, input logic exp_v, input int e0, input int e1);
        repeat (4) @(posedge clk);
        #1 check({tag, " valid@E0+4"}, 32'(u_if.pos_valid), 32'd0);
        @(posedge clk);
        #1 check({tag, " valid@E0+5"}, 32'(u_if.pos_valid), 32'(exp_v));
        check({tag, " pos0"}, 32'(u_if.pos[PW-1:0]), 32'(e0));
        check({tag, " pos1"}, 32'(u_if.pos[2*PW-1:PW]), 32'(e1));
        @(posedge clk);
        #1 check({tag, " valid@E0+6"}, 32'(u_if.pos_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        u_if.adc_busy    = 1'b0;
        u_if.adc_data    = '0;
        u_if.freeze      = 1'b0;
        u_if.clr_overrun = 1'b0;

        // 1. Reset state and first frame
        do_reset();
        #1;
        check("rst pos", 32'(u_if.pos), 32'd0);
        check("rst valid", 32'(u_if.pos_valid), 32'd0);
        check("rst overrun", 32'(u_if.overrun), 32'd0);
        start_frame(255, 0);
        finish_frame("first", 1'b1, 418, 0);

        // 2. Filter step response
        do_reset();
        start_frame(0, 0);
        finish_frame("prime0", 1'b1, 0, 0);
        start_frame(128, 0);
        finish_frame("step1", 1'b1, 52, 0);
        start_frame(128, 0);
        finish_frame("step2", 1'b1, 91, 0);
        start_frame(128, 0);
        finish_frame("step3", 1'b1, 121, 0);

        // 3. Deadband
        do_reset();
        start_frame(100, 0);
        finish_frame("db prime", 1'b1, 164, 0);
        start_frame(104, 0);
        finish_frame("db hold", 1'b1, 164, 0);
        start_frame(255, 0);
        finish_frame("db move", 1'b1, 228, 0);

        // 4. Overrun
        do_reset();
        start_frame(255, 0);
        @(negedge clk);
        u_if.adc_data = {SW'(255), SW'(0)};
        u_if.adc_busy = 1'b1;
        @(negedge clk);
        u_if.adc_busy = 1'b0;
        @(posedge clk);
        #1 check("ovr set", 32'(u_if.overrun), 32'd1);
        repeat (2) @(posedge clk);
        #1 check("ovr valid@E0+4", 32'(u_if.pos_valid), 32'd0);
        @(posedge clk);
        #1 check("ovr valid@E0+5", 32'(u_if.pos_valid), 32'd1);
        check("ovr pos0", 32'(u_if.pos[PW-1:0]), 32'd418);
        check("ovr pos1", 32'(u_if.pos[2*PW-1:PW]), 32'd0);
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (u_if.pos_valid) pulses++;
        end
        check("ovr extra pulses", 32'(pulses), 32'd0);
        check("ovr pos0 kept", 32'(u_if.pos[PW-1:0]), 32'd418);
        check("ovr sticky", 32'(u_if.overrun), 32'd1);
        @(negedge clk);
        u_if.clr_overrun = 1'b1;
        @(negedge clk);
        u_if.clr_overrun = 1'b0;
        check("ovr cleared", 32'(u_if.overrun), 32'd0);
        start_frame(10, 10);
        @(negedge clk);
        u_if.adc_busy = 1'b1;
        @(negedge clk);
        u_if.adc_busy    = 1'b0;
        u_if.clr_overrun = 1'b1;
        @(posedge clk);
        #1 check("ovr set wins", 32'(u_if.overrun), 32'd1);
        @(negedge clk);
        u_if.clr_overrun = 1'b0;
        repeat (6) @(posedge clk);

        // 5. Freeze and thaw bypass
        do_reset();
        start_frame(100, 0);
        finish_frame("frz prime", 1'b1, 164, 0);
        @(negedge clk);
        u_if.freeze = 1'b1;
        start_frame(200, 0);
        finish_frame("frz held", 1'b0, 164, 0);
        @(negedge clk);
        u_if.freeze = 1'b0;
        start_frame(29, 0);
        finish_frame("frz thaw", 1'b1, 165, 0);

        // 6. Reset mid-frame
        do_reset();
        start_frame(255, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst pos", 32'(u_if.pos), 32'd0);
        check("mid rst overrun", 32'(u_if.overrun), 32'd0);
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1 if (u_if.pos_valid) pulses++;
        end
        check("mid rst pulses", 32'(pulses), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(64, 0);
        finish_frame("mid rst reprime", 1'b1, 105, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
